noise_sel_loader: RTL and testbench
===================================

Name: noise_sel_loader

Overview:
- Upstream feeder for the noise-select mapping core.
- Receives a framed, MSB-first serial word of DATA_W bits plus one even-parity bit on the system clock.
- Checks parity, then presents the word on noise_data with valid held for HOLD_CYCLES cycles, so the downstream core latches it as its noise select.
- Also reports busy, a sticky parity error and an accepted-frame count.

Parameters:
- DATA_W, 16: serial payload width; equals the downstream noise_data width.
- HOLD_CYCLES, 2: cycles valid stays high per accepted frame; legal range is >= 1.
- TIMEOUT, 255: idle-bit watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- load_start  input  1  single-cycle pulse that opens a frame.
- ser_en  input  1  qualifies ser_in for one clk cycle.
- ser_in  input  1  serial data bit, MSB first, followed by the parity bit.
- valid  output  1  high while noise_data carries a freshly accepted word.
- noise_data  output  DATA_W  last accepted word.
- busy  output  1  high in SHIFT, PAR or OUT.
- par_err  output  1  sticky parity (or timeout) error; cleared by load_start.
- frame_cnt  output  8  count of accepted frames; wraps 255 to 0.

Behaviour:
- Reset values (asynchronous): state IDLE, valid 0, noise_data all ones (16'hFFFF), busy 0, par_err 0, frame_cnt 0, all internal counters 0.
- IDLE: on load_start, clear the shift register and bit_cnt and go to SHIFT. In the start cycle, ser_en/ser_in are ignored. With ser_en alone and no load_start, nothing happens.
- SHIFT: on each cycle with ser_en=1, shift ser_in into the LSB (MSB-first assembly) and increment bit_cnt. When the DATA_W-th bit is sampled, go to PAR.
- PAR: on ser_en=1, compare ser_in against the XOR of the shifted word.
  - Match: on that same edge, load noise_data with the word, set valid=1, increment frame_cnt and go to OUT. Latency is 0 cycles after the parity sample edge.
  - Mismatch: set par_err=1, leave noise_data unchanged, keep valid 0 and go to IDLE.
- OUT: hold valid=1 for exactly HOLD_CYCLES cycles, then clear valid and go to IDLE. load_start and ser_en are ignored in OUT.
- Restart: load_start in SHIFT or PAR discards the partial frame, clears bit_cnt and par_err, and re-enters SHIFT. Any ser_en bit in that same cycle is dropped.
- par_err: cleared only by an accepted load_start, i.e. in IDLE, SHIFT or PAR.
- busy: registered, equal to (state != IDLE).
- noise_data: changes only on an accepted frame and is otherwise stable.
- Counter widths:
  - bit_cnt: $clog2(DATA_W+1) bits.
  - hold_cnt: $clog2(HOLD_CYCLES+1) bits.
  - frame_cnt: 8 bits, modulo 256.
- Gaps of any length between ser_en pulses are legal, unless the optional feature is enabled.
- Reset asserted mid-frame: immediate return to reset values. Any partial word is lost and noise_data returns to 16'hFFFF.

Optional Feature:
- Macro: NOISE_SEL_LOADER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in SHIFT and PAR. It resets on each ser_en or load_start and increments otherwise.
  - On reaching TIMEOUT cycles without ser_en, the frame is aborted: par_err=1, state to IDLE, noise_data and frame_cnt unchanged, valid stays 0.
- Not defined: no watchdog logic is built, the TIMEOUT parameter is unused, and the block waits indefinitely in SHIFT/PAR.

Test Plan:
- Good frame: load_start, then 16 bits of 0xA5C3 MSB first, then parity 0 -> noise_data=0xA5C3 on the parity edge, valid high exactly 2 cycles, frame_cnt=1, par_err=0, busy falls one cycle after valid drops.
- Bad parity: same word with parity 1 -> par_err=1, valid stays 0, noise_data remains 0xFFFF, frame_cnt=0. A following load_start clears par_err.
- Restart: load_start, 7 bits, load_start with ser_en in the same cycle, then a full 0x1234 frame (parity 1) -> noise_data=0x1234. The dropped bit and the partial bits have no effect.
- Reset mid-frame: deassert rst_n after 10 bits -> all outputs return to reset values immediately. A subsequent full frame 0x00FF (parity 0) is accepted normally.
- Wrap and OUT-ignore: send 256 good frames, pulsing load_start during each OUT phase -> frame_cnt wraps to 0, and no frame is started from the OUT-phase pulses.
- Timeout (macro defined, TIMEOUT=8): load_start, 3 bits, then 8 idle cycles -> par_err=1, state IDLE, valid 0. Without the macro -> the block stays busy and completes the frame when bits resume.

Source files
------------

// File: rtl/noise_sel_loader.sv
// Serial loader feeding the noise-select core: assembles an MSB-first word, checks
// even parity and presents it with valid held for HOLD_CYCLES. Optional idle-bit
// watchdog is built when NOISE_SEL_LOADER_TIMEOUT_EN is defined.
module noise_sel_loader #(
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              ser_en,
    input  logic              ser_in,
    output logic              valid,
    output logic [DATA_W-1:0] noise_data,
    output logic              busy,
    output logic              par_err,
    output logic [7:0]        frame_cnt
);

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAR, OUT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                par_err_q, par_err_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                busy_q;

`ifdef NOISE_SEL_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        par_err_d   = par_err_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A restart wins over any bit presented in the same cycle.
                if (load_start) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                end else if (ser_en) begin
                    shift_d   = {shift_q[DATA_W-2:0], ser_in};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1))
                        state_d = PAR;
                end
            end
            PAR: begin
                if (load_start) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                    state_d   = SHIFT;
                end else if (ser_en) begin
                    if (ser_in == (^shift_q)) begin
                        data_d      = shift_q;
                        valid_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        hold_cnt_d  = '0;
                        state_d     = OUT;
                    end else begin
                        par_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            OUT: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef NOISE_SEL_LOADER_TIMEOUT_EN
        // Abort only fires on cycles with no ser_en/load_start, so it never collides
        // with the shift or parity decisions above.
        wd_cnt_d = '0;
        if (state_q == SHIFT || state_q == PAR) begin
            if (load_start || ser_en) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                par_err_d = 1'b1;
                state_d   = IDLE;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            data_q      <= '1;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= (state_q != IDLE);
        end
    end

`ifdef NOISE_SEL_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt_q <= '0;
        else        wd_cnt_q <= wd_cnt_d;
    end
`endif

    assign valid      = valid_q;
    assign noise_data = data_q;
    assign busy       = busy_q;
    assign par_err    = par_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_noise_sel_loader.sv
// Directed bench for noise_sel_loader: good/bad parity, restart, async reset,
// counter wrap with OUT-phase pulses, and the watchdog build option.
module tb_noise_sel_loader;

`ifdef NOISE_SEL_LOADER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        ser_en = 1'b0;
    logic        ser_in = 1'b0;
    logic        valid;
    logic [15:0] noise_data;
    logic        busy;
    logic        par_err;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    noise_sel_loader #(.DATA_W(16), .HOLD_CYCLES(2), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .ser_en     (ser_en),
        .ser_in     (ser_in),
        .valid      (valid),
        .noise_data (noise_data),
        .busy       (busy),
        .par_err    (par_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        ser_en = 1'b1;
        ser_in = b;
        tick();
        ser_en = 1'b0;
        ser_in = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (noise_data !== 16'hFFFF) begin errors++; $display("FAIL reset_data got=%h exp=ffff", noise_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got=%0b exp=0", par_err); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        rst_n = 1'b1;
        // ser_en alone in IDLE must not start anything
        send_bit(1'b1);
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ser_en_busy got=%0b exp=0", busy); end
        $display("reset: data=%h cnt=%0d", noise_data, frame_cnt);
    endtask

    task automatic test_bad_parity();
        start();
        send_bits(16'hA5C3, 15, 0);
        send_bit(1'b1);
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL bad_par_err got=%0b exp=1", par_err); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bad_par_valid got=%0b exp=0", valid); end
        checks++; if (noise_data !== 16'hFFFF) begin errors++; $display("FAIL bad_par_data got=%h exp=ffff", noise_data); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL bad_par_cnt got=%0d exp=0", frame_cnt); end
        tick();
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL bad_par_sticky got=%0b exp=1", par_err); end
        start();
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL bad_par_clear got=%0b exp=0", par_err); end
        $display("bad parity frame: par_err cleared by load_start");
    endtask

    task automatic test_good_frame();
        start();
        send_bits(16'hA5C3, 15, 0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL good_pre_valid got=%0b exp=0", valid); end
        send_bit(1'b0);
        checks++; if (noise_data !== 16'hA5C3) begin errors++; $display("FAIL good_data got=%h exp=a5c3", noise_data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL good_valid0 got=%0b exp=1", valid); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL good_cnt got=%0d exp=1", frame_cnt); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL good_par_err got=%0b exp=0", par_err); end
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL good_valid1 got=%0b exp=1", valid); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL good_valid2 got=%0b exp=0", valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_hold got=%0b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_fall got=%0b exp=0", busy); end
        $display("good frame: data=%h cnt=%0d", noise_data, frame_cnt);
    endtask

    task automatic test_restart();
        start();
        send_bits(16'hFFFF, 6, 0);
        load_start = 1'b1;
        ser_en = 1'b1;
        ser_in = 1'b1;
        tick();
        load_start = 1'b0;
        ser_en = 1'b0;
        ser_in = 1'b0;
        send_bits(16'h1234, 15, 0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL restart_pre_valid got=%0b exp=0", valid); end
        send_bit(1'b1);
        checks++; if (noise_data !== 16'h1234) begin errors++; $display("FAIL restart_data got=%h exp=1234", noise_data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL restart_valid got=%0b exp=1", valid); end
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL restart_cnt got=%0d exp=2", frame_cnt); end
        repeat (3) tick();
        $display("restart frame: data=%h cnt=%0d", noise_data, frame_cnt);
    endtask

    task automatic test_reset_mid_frame();
        start();
        send_bits(16'h00FF, 15, 6);
        rst_n = 1'b0;
        #1;
        checks++; if (noise_data !== 16'hFFFF) begin errors++; $display("FAIL midrst_data got=%h exp=ffff", noise_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", frame_cnt); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", valid); end
        tick();
        rst_n = 1'b1;
        start();
        send_bits(16'h00FF, 15, 0);
        send_bit(1'b0);
        checks++; if (noise_data !== 16'h00FF) begin errors++; $display("FAIL midrst_after_data got=%h exp=00ff", noise_data); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_after_cnt got=%0d exp=1", frame_cnt); end
        repeat (3) tick();
        $display("reset mid-frame then frame: data=%h cnt=%0d", noise_data, frame_cnt);
    endtask

    task automatic test_wrap_out_ignore();
        logic [15:0] w;
        logic [7:0]  exp_cnt;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 16'(i * 16'h0101) ^ 16'h5A3C;
            exp_cnt = 8'(i + 1);
            start();
            send_bits(w, 15, 0);
            send_bit(^w);
            checks++; if (noise_data !== w) begin errors++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, noise_data, w); end
            checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt i=%0d got=%0d exp=%0d", i, frame_cnt, exp_cnt); end
            load_start = 1'b1;
            ser_en = 1'b1;
            ser_in = 1'b1;
            tick();
            load_start = 1'b0;
            ser_en = 1'b0;
            ser_in = 1'b0;
            tick();
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_out_ignore i=%0d busy got=%0b exp=0", i, busy); end
            $display("wrap frame %0d: data=%h cnt=%0d", i, noise_data, frame_cnt);
        end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_final got=%0d exp=0", frame_cnt); end
    endtask

    task automatic test_timeout();
        start();
        send_bits(16'hA5C3, 15, 13);
`ifdef NOISE_SEL_LOADER_TIMEOUT_EN
        repeat (7) tick();
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%0b exp=0", par_err); end
        tick();
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL timeout_par_err got=%0b exp=1", par_err); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL timeout_valid got=%0b exp=0", valid); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL timeout_cnt got=%0d exp=0", frame_cnt); end
        $display("timeout: frame aborted, par_err=%0b", par_err);
`else
        repeat (20) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nowd_busy got=%0b exp=1", busy); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL nowd_par_err got=%0b exp=0", par_err); end
        send_bits(16'hA5C3, 12, 0);
        send_bit(1'b0);
        checks++; if (noise_data !== 16'hA5C3) begin errors++; $display("FAIL nowd_data got=%h exp=a5c3", noise_data); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL nowd_cnt got=%0d exp=1", frame_cnt); end
        repeat (3) tick();
        $display("no watchdog: stalled frame completed, data=%h", noise_data);
`endif
    endtask

    initial begin
        test_reset();
        test_bad_parity();
        test_good_frame();
        test_restart();
        test_reset_mid_frame();
        test_wrap_out_ignore();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
